// File: rtl/sram_arb_pkg.sv
// Shared encodings for the SRAM arbiter: FSM state enum, one-hot grant values and op codes.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY_MEM = 2'd1,
        ST_BUSY_IF  = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_MEM  = 2'b01;
    localparam logic [1:0] GNT_IF   = 2'b10;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/sram_arbiter_if.sv
// Bundle of the MEM, IF and SRAM-controller side signals around the arbiter.
interface sram_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              mem_rd_en;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_adr;
    logic [DATA_W-1:0] mem_wr_data;
    logic [DATA_W-1:0] mem_rd_data;
    logic              mem_ready;
    logic              mem_stall;

    logic              if_rd_en;
    logic [ADDR_W-1:0] if_adr;
    logic [DATA_W-1:0] if_rd_data;
    logic              if_ready;
    logic              if_stall;

    logic              ctrl_rd_en;
    logic              ctrl_wr_en;
    logic [ADDR_W-1:0] ctrl_adr;
    logic [DATA_W-1:0] ctrl_wr_data;
    logic [DATA_W-1:0] ctrl_rd_data;
    logic              ctrl_ready;

    logic [1:0]        grant;

    // Arbiter view
    modport slave (
        input  mem_rd_en, mem_wr_en, mem_adr, mem_wr_data,
        output mem_rd_data, mem_ready, mem_stall,
        input  if_rd_en, if_adr,
        output if_rd_data, if_ready, if_stall,
        output ctrl_rd_en, ctrl_wr_en, ctrl_adr, ctrl_wr_data,
        input  ctrl_rd_data, ctrl_ready,
        output grant
    );

    // Environment view (pipeline stages plus SRAM controller)
    modport master (
        output mem_rd_en, mem_wr_en, mem_adr, mem_wr_data,
        input  mem_rd_data, mem_ready, mem_stall,
        output if_rd_en, if_adr,
        input  if_rd_data, if_ready, if_stall,
        input  ctrl_rd_en, ctrl_wr_en, ctrl_adr, ctrl_wr_data,
        output ctrl_rd_data, ctrl_ready,
        input  grant
    );

endinterface

// File: rtl/sram_arb_pick.sv
// Combinational winner picker: fixed MEM-over-IF priority, or alternation on contention
// when SRAM_ARB_ROUND_ROBIN_EN is defined (last_grant: 0 = MEM won last, 1 = IF).
module sram_arb_pick
    import sram_arb_pkg::*;
(
    input  logic       mem_req,
    input  logic       if_req,
    input  logic       last_grant,
    output logic [1:0] winner
);

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    always_comb begin
        winner = GNT_NONE;
        if (mem_req && if_req) begin
            winner = last_grant ? GNT_MEM : GNT_IF;
        end else if (mem_req) begin
            winner = GNT_MEM;
        end else if (if_req) begin
            winner = GNT_IF;
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        winner = GNT_NONE;
        if (mem_req) begin
            winner = GNT_MEM;
        end else if (if_req) begin
            winner = GNT_IF;
        end
    end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// SRAM port arbiter: MEM (rd/wr) and IF (rd) share one controller, one transaction per grant.
// Define SRAM_ARB_ROUND_ROBIN_EN to alternate the winner when both ports request together.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    sram_arbiter_if.slave bus
);

    localparam logic [1:0] IDLE     = ST_IDLE;
    localparam logic [1:0] BUSY_MEM = ST_BUSY_MEM;
    localparam logic [1:0] BUSY_IF  = ST_BUSY_IF;

    logic [1:0]        state_reg;
    logic [1:0]        grant_reg;
    logic              active_reg;
    logic              op_reg;
    logic [ADDR_W-1:0] adr_reg;
    logic [DATA_W-1:0] wr_data_reg;
    logic [DATA_W-1:0] mem_rd_data_reg;
    logic [DATA_W-1:0] if_rd_data_reg;
    logic              mem_ready_reg;
    logic              if_ready_reg;
    logic              last_grant;
    logic              mem_req;
    logic [1:0]        winner;

    assign mem_req = bus.mem_rd_en | bus.mem_wr_en;

    sram_arb_pick u_pick (
        .mem_req    (mem_req),
        .if_req     (bus.if_rd_en),
        .last_grant (last_grant),
        .winner     (winner)
    );

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic last_grant_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_reg <= 1'b0;
        end else if (state_reg == IDLE && winner != GNT_NONE) begin
            last_grant_reg <= winner[1];
        end
    end

    assign last_grant = last_grant_reg;
`else
    assign last_grant = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IDLE;
            grant_reg       <= GNT_NONE;
            active_reg      <= 1'b0;
            op_reg          <= OP_RD;
            adr_reg         <= '0;
            wr_data_reg     <= '0;
            mem_rd_data_reg <= '0;
            if_rd_data_reg  <= '0;
            mem_ready_reg   <= 1'b0;
            if_ready_reg    <= 1'b0;
        end else begin
            mem_ready_reg <= 1'b0;
            if_ready_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (winner == GNT_MEM) begin
                        state_reg   <= BUSY_MEM;
                        grant_reg   <= GNT_MEM;
                        active_reg  <= 1'b1;
                        // A write wins over a simultaneous read request
                        op_reg      <= bus.mem_wr_en ? OP_WR : OP_RD;
                        adr_reg     <= bus.mem_adr;
                        wr_data_reg <= bus.mem_wr_data;
                    end else if (winner == GNT_IF) begin
                        state_reg   <= BUSY_IF;
                        grant_reg   <= GNT_IF;
                        active_reg  <= 1'b1;
                        op_reg      <= OP_RD;
                        adr_reg     <= bus.if_adr;
                        wr_data_reg <= '0;
                    end
                end
                BUSY_MEM, BUSY_IF: begin
                    if (bus.ctrl_ready) begin
                        state_reg  <= ST_DONE;
                        active_reg <= 1'b0;
                        if (state_reg == BUSY_MEM) begin
                            mem_ready_reg <= 1'b1;
                            if (op_reg == OP_RD) begin
                                mem_rd_data_reg <= bus.ctrl_rd_data;
                            end
                        end else begin
                            if_ready_reg   <= 1'b1;
                            if_rd_data_reg <= bus.ctrl_rd_data;
                        end
                    end
                end
                default: begin
                    // DONE: ready pulse is out this cycle; requests are not sampled
                    state_reg   <= IDLE;
                    grant_reg   <= GNT_NONE;
                    op_reg      <= OP_RD;
                    adr_reg     <= '0;
                    wr_data_reg <= '0;
                end
            endcase
        end
    end

    assign bus.ctrl_rd_en   = active_reg & (op_reg == OP_RD);
    assign bus.ctrl_wr_en   = active_reg & (op_reg == OP_WR);
    assign bus.ctrl_adr     = adr_reg;
    assign bus.ctrl_wr_data = wr_data_reg;
    assign bus.grant        = grant_reg;
    assign bus.mem_rd_data  = mem_rd_data_reg;
    assign bus.mem_ready    = mem_ready_reg;
    assign bus.if_rd_data   = if_rd_data_reg;
    assign bus.if_ready     = if_ready_reg;
    assign bus.mem_stall    = mem_req & ~mem_ready_reg;
    assign bus.if_stall     = bus.if_rd_en & ~if_ready_reg;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: directed cases then randomized MEM/IF traffic against a
// behavioural SRAM controller; expectations come from a reference memory and arbitration rules.
`timescale 1ns/1ps
module tb_sram_arbiter;
    import sram_arb_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memories: controller storage and reference model ----------------
    logic [31:0] sram    [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] sram_read(input logic [31:0] a);
        return sram.exists(a) ? sram[a] : init_word(a);
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    // Expected read data per port, in completion order
    logic [31:0] mem_exp [$];
    logic [31:0] if_exp  [$];
    logic [31:0] mem_last_rd = '0;
    bit          last_served_if = 1'b0;
    int          last_en_run = 0;

    // ---------------- behavioural SRAM controller ----------------
    int ctrl_lat_cfg = 0;
    bit spur_en = 1'b0;

    initial begin
        int cnt;
        int lat;
        cnt = 0;
        lat = 1;
        bus.ctrl_ready   = 1'b0;
        bus.ctrl_rd_data = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.ctrl_ready = 1'b0;
            if (!rst) begin
                cnt = 0;
            end else if (bus.ctrl_rd_en || bus.ctrl_wr_en) begin
                if (cnt == 0) lat = (ctrl_lat_cfg != 0) ? ctrl_lat_cfg : int'($urandom_range(1, 4));
                cnt++;
                if (cnt >= lat) begin
                    bus.ctrl_ready = 1'b1;
                    if (bus.ctrl_wr_en) sram[bus.ctrl_adr] = bus.ctrl_wr_data;
                    else bus.ctrl_rd_data = sram_read(bus.ctrl_adr);
                    cnt = 0;
                end
            end else begin
                cnt = 0;
                // stray completion pulses while nothing is outstanding must be ignored
                if (spur_en && $urandom_range(0, 7) == 0) begin
                    bus.ctrl_ready   = 1'b1;
                    bus.ctrl_rd_data = $urandom;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic en, en_prev, mr_prev, ir_prev, mreq_prev, ireq_prev, want_if;
        int   en_run;
        en_prev = 1'b0; mr_prev = 1'b0; ir_prev = 1'b0;
        mreq_prev = 1'b0; ireq_prev = 1'b0; en_run = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                en_prev = 1'b0; mr_prev = 1'b0; ir_prev = 1'b0; en_run = 0;
                last_served_if = 1'b0;
                mem_last_rd = '0;
            end else begin
                en = bus.ctrl_rd_en | bus.ctrl_wr_en;
                if (en && !en_prev) begin
                    want_if = ireq_prev && (!mreq_prev || (RR && !last_served_if));
                    check1("start_had_request", mreq_prev | ireq_prev, 1'b1);
                    check32("grant_on_start", 32'(bus.grant), want_if ? 32'(GNT_IF) : 32'(GNT_MEM));
                    check32("ctrl_adr_on_start", bus.ctrl_adr, want_if ? bus.if_adr : bus.mem_adr);
                    check1("ctrl_wr_en_on_start", bus.ctrl_wr_en, !want_if && bus.mem_wr_en);
                    check1("ctrl_rd_en_on_start", bus.ctrl_rd_en, want_if || !bus.mem_wr_en);
                    if (!want_if && bus.mem_wr_en)
                        check32("ctrl_wr_data_on_start", bus.ctrl_wr_data, bus.mem_wr_data);
                    last_served_if = want_if;
                end
                if (en) begin
                    en_run++;
                end else if (en_prev) begin
                    last_en_run = en_run;
                    en_run = 0;
                end
                if (bus.mem_ready) begin
                    check1("mem_ready_single_pulse", mr_prev, 1'b0);
                    check1("mem_ready_expected", mem_exp.size() != 0, 1'b1);
                    if (mem_exp.size() != 0) check32("mem_rd_data", bus.mem_rd_data, mem_exp.pop_front());
                    check32("grant_mem_done", 32'(bus.grant), 32'(GNT_MEM));
                end
                if (bus.if_ready) begin
                    check1("if_ready_single_pulse", ir_prev, 1'b0);
                    check1("if_ready_expected", if_exp.size() != 0, 1'b1);
                    if (if_exp.size() != 0) check32("if_rd_data", bus.if_rd_data, if_exp.pop_front());
                    check32("grant_if_done", 32'(bus.grant), 32'(GNT_IF));
                end
                if (!en && !bus.mem_ready && !bus.if_ready)
                    check32("grant_idle", 32'(bus.grant), 32'(GNT_NONE));
                check1("mem_stall", bus.mem_stall, (bus.mem_rd_en | bus.mem_wr_en) & ~bus.mem_ready);
                check1("if_stall", bus.if_stall, bus.if_rd_en & ~bus.if_ready);
                en_prev = en;
                mr_prev = bus.mem_ready;
                ir_prev = bus.if_ready;
            end
            mreq_prev = bus.mem_rd_en | bus.mem_wr_en;
            ireq_prev = bus.if_rd_en;
        end
    end

    // ---------------- requester tasks (called at posedge + 1) ----------------
    task automatic wait_ready(input bit is_if);
        int n;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (is_if ? bus.if_ready : bus.mem_ready) break;
        end
        if (n == 200) begin
            checks++;
            errors++;
            $display("FAIL %s_ready_timeout: no ready after 200 cycles, expected one", is_if ? "if" : "mem");
            if (is_if) if_exp.delete();
            else mem_exp.delete();
        end
    endtask

    task automatic mem_do(input bit wr, input bit rd, input logic [31:0] adr, input logic [31:0] data);
        if (wr) begin
            ref_mem[adr] = data;
        end else begin
            mem_last_rd = ref_read(adr);
        end
        mem_exp.push_back(mem_last_rd);
        bus.mem_wr_en   = wr;
        bus.mem_rd_en   = rd | !wr;
        bus.mem_adr     = adr;
        bus.mem_wr_data = data;
        wait_ready(1'b0);
        @(posedge clk);
        #1;
        bus.mem_rd_en = 1'b0;
        bus.mem_wr_en = 1'b0;
    endtask

    task automatic if_do(input logic [31:0] adr);
        if_exp.push_back(ref_read(adr));
        bus.if_rd_en = 1'b1;
        bus.if_adr   = adr;
        wait_ready(1'b1);
        @(posedge clk);
        #1;
        bus.if_rd_en = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check1({tag, "_ctrl_rd_en"}, bus.ctrl_rd_en, 1'b0);
        check1({tag, "_ctrl_wr_en"}, bus.ctrl_wr_en, 1'b0);
        check32({tag, "_ctrl_adr"}, bus.ctrl_adr, 32'h0);
        check32({tag, "_ctrl_wr_data"}, bus.ctrl_wr_data, 32'h0);
        check32({tag, "_grant"}, 32'(bus.grant), 32'(GNT_NONE));
        check1({tag, "_mem_ready"}, bus.mem_ready, 1'b0);
        check1({tag, "_if_ready"}, bus.if_ready, 1'b0);
        check32({tag, "_mem_rd_data"}, bus.mem_rd_data, 32'h0);
        check32({tag, "_if_rd_data"}, bus.if_rd_data, 32'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        bus.mem_rd_en = 1'b0; bus.mem_wr_en = 1'b0; bus.mem_adr = '0; bus.mem_wr_data = '0;
        bus.if_rd_en = 1'b0; bus.if_adr = '0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("in_reset");
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("after_reset");
        @(posedge clk);
        #1;

        // MEM write, controller answers on its 4th busy cycle
        ctrl_lat_cfg = 4;
        mem_do(1'b1, 1'b0, 32'h0000_0040, 32'hDEAD_BEEF);
        check32("wr_en_high_cycles", 32'(last_en_run), 32'd4);

        // IF read of a preloaded word
        ctrl_lat_cfg = 2;
        sram[32'h0000_0100]    = 32'h1234_5678;
        ref_mem[32'h0000_0100] = 32'h1234_5678;
        if_do(32'h0000_0100);

        // read and write together: write must win; then read back the first write
        ctrl_lat_cfg = 1;
        mem_do(1'b1, 1'b1, 32'h0000_0044, 32'hCAFE_F00D);
        mem_do(1'b0, 1'b0, 32'h0000_0040, 32'h0);

        // simultaneous MEM and IF reads (last winner was MEM)
        ctrl_lat_cfg = 3;
        fork
            mem_do(1'b0, 1'b0, 32'h0000_0080, 32'h0);
            if_do(32'h0000_0104);
        join

        // reset dropped in the middle of a MEM read
        ctrl_lat_cfg = 6;
        bus.mem_rd_en = 1'b1;
        bus.mem_adr   = 32'h0000_0088;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.ctrl_rd_en) break;
        end
        check1("abort_busy_reached", bus.ctrl_rd_en, 1'b1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check1("abort_ctrl_rd_en_async", bus.ctrl_rd_en, 1'b0);
        check1("abort_ctrl_wr_en_async", bus.ctrl_wr_en, 1'b0);
        check32("abort_grant_async", 32'(bus.grant), 32'(GNT_NONE));
        bus.mem_rd_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        mem_do(1'b0, 1'b0, 32'h0000_0088, 32'h0);

        // randomized concurrent traffic
        ctrl_lat_cfg = 0;
        spur_en = 1'b1;
        fork
            begin
                int idle;
                bit wr, rd;
                logic [31:0] adr;
                for (int i = 0; i < 60; i++) begin
                    idle = int'($urandom_range(0, 3));
                    repeat (idle) begin @(posedge clk); #1; end
                    wr  = 1'($urandom_range(0, 1));
                    rd  = 1'($urandom_range(0, 1));
                    adr = wr ? (32'($urandom_range(0, 63)) << 2) : (32'($urandom_range(0, 127)) << 2);
                    mem_do(wr, rd, adr, $urandom);
                end
            end
            begin
                int idle;
                for (int i = 0; i < 60; i++) begin
                    idle = int'($urandom_range(0, 3));
                    repeat (idle) begin @(posedge clk); #1; end
                    if_do(32'h0000_0100 + (32'($urandom_range(0, 63)) << 2));
                end
            end
        join
        spur_en = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check32("mem_queue_drained", 32'(mem_exp.size()), 32'd0);
        check32("if_queue_drained", 32'(if_exp.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected to end earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
